// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the uart_fifo_core transceiver
//
// Purpose: parity mode encoding, TX/RX state enums, oversampling constants
//          and a parity helper shared by the core and its sub-modules.
// Ports:   none (package).
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_mode_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] MID_SAMPLE = 4'd7;
  localparam logic [3:0] TICK_LAST  = 4'(OVERSAMPLE - 1);

  // Mode 2'b11 is deliberately treated like PAR_NONE.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - first-word fall-through synchronous FIFO
//
// Purpose: small FWFT queue; the head is visible on rdata_o while not empty
//          and the last popped head is held when the FIFO drains.
// Ports:   clk, rst_n (async, active-low)
//          push_i/wdata_i  write side; a push while full is ignored unless
//                          a pop happens in the same cycle
//          pop_i           pops the head (ignored when empty)
//          rdata_o         head entry (or last head when empty)
//          full_o, empty_o status
module uart_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit above the index.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] last_q;
  logic [WIDTH-1:0] head;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so the push may land at full.
  assign do_push = push_i && (!full_o || do_pop);

  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign rdata_o = empty_o ? last_q : head;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      // Shadow of the head so the output holds once the queue empties.
      if (!empty_o) last_q <= head;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_fifo_core.sv
// rtl/uart_fifo_core.sv - 16x-oversampled UART transceiver with buffered RX
//
// Purpose: UART with a single-character TX holding register and an RX FIFO
//          storing per-character parity/framing error flags.
// Optional: UART_LOOPBACK_EN adds input 'loopback' routing internal tx into
//           the receiver while holding the tx pin at 1.
// Ports:   mclkx16 (16x baud clock), reset (async, active-low)
//          paritymode  00 none, 01 even, 10 odd, 11 none
//          rx, tx      serial lines, idle high
//          read        active-low pop; rxrdy, dataout, parityerr,
//                      framingerr show the FIFO head; overrun sticky drop flag
//          write       active-low load of datain; txrdy holding register free
module uart_fifo_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int RX_DEPTH  = 4
) (
  input  logic                 mclkx16,
  input  logic                 reset,
  input  logic [1:0]           paritymode,
  input  logic                 rx,
  input  logic                 read,
  output logic                 rxrdy,
  output logic [DATA_BITS-1:0] dataout,
  output logic                 parityerr,
  output logic                 framingerr,
  output logic                 overrun,
  input  logic                 write,
  input  logic [DATA_BITS-1:0] datain,
  output logic                 txrdy,
`ifdef UART_LOOPBACK_EN
  input  logic                 loopback,
`endif
  output logic                 tx
);

  // ---------------------------------------------------------------- TX
  tx_state_e            tx_state_q;
  logic [3:0]           tx_tick_q;
  logic [2:0]           tx_bit_q;
  logic                 tx_stop_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 tx_par_q;
  logic                 tx_paren_q;
  logic                 tx_q;
  logic                 txrdy_q;
  logic                 tx_last_stop;
  logic                 tx_accept;

  assign tx_last_stop = (tx_state_q == TX_STOP) && (tx_tick_q == TICK_LAST) &&
                        (tx_stop_q == 1'(STOP_BITS - 1));
  // A held write chains the next frame straight after the final stop bit.
  assign tx_accept    = !write && ((tx_state_q == TX_IDLE) || tx_last_stop);

  always_ff @(posedge mclkx16 or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_stop_q  <= 1'b0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_paren_q <= 1'b0;
      tx_q       <= 1'b1;
      txrdy_q    <= 1'b1;
    end else if (tx_accept) begin
      tx_state_q <= TX_START;
      tx_tick_q  <= '0;
      tx_shift_q <= datain;
      tx_par_q   <= (^datain) ^ (paritymode == PAR_ODD);
      tx_paren_q <= parity_enabled(paritymode);
      tx_q       <= 1'b0;
      txrdy_q    <= 1'b0;
    end else if (tx_state_q != TX_IDLE) begin
      tx_tick_q <= tx_tick_q + 4'd1;
      if (tx_tick_q == TICK_LAST) begin
        case (tx_state_q)
          TX_START: begin
            tx_state_q <= TX_DATA;
            tx_bit_q   <= '0;
            tx_q       <= tx_shift_q[0];
          end
          TX_DATA: begin
            if (tx_bit_q == 3'(DATA_BITS - 1)) begin
              tx_state_q <= tx_paren_q ? TX_PARITY : TX_STOP;
              tx_q       <= tx_paren_q ? tx_par_q : 1'b1;
              tx_stop_q  <= 1'b0;
            end else begin
              tx_bit_q   <= tx_bit_q + 3'd1;
              tx_shift_q <= tx_shift_q >> 1;
              tx_q       <= tx_shift_q[1];
            end
          end
          TX_PARITY: begin
            tx_state_q <= TX_STOP;
            tx_q       <= 1'b1;
            tx_stop_q  <= 1'b0;
          end
          TX_STOP: begin
            if (tx_stop_q == 1'(STOP_BITS - 1)) begin
              tx_state_q <= TX_IDLE;
              txrdy_q    <= 1'b1;
            end else begin
              tx_stop_q <= tx_stop_q + 1'b1;
            end
          end
          default: tx_state_q <= TX_IDLE;
        endcase
      end
    end
  end

  assign txrdy = txrdy_q;

  // ---------------------------------------------------------------- line routing
  logic rx_src;
`ifdef UART_LOOPBACK_EN
  assign rx_src = loopback ? tx_q : rx;
  assign tx     = loopback ? 1'b1 : tx_q;
`else
  assign rx_src = rx;
  assign tx     = tx_q;
`endif

  // ---------------------------------------------------------------- RX
  rx_state_e            rx_state_q;
  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  logic [3:0]           rx_tick_q;
  logic [2:0]           rx_bit_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic [1:0]           rx_pmode_q;
  logic                 rx_perr_q;
  logic                 rx_sample;
  logic                 rx_push;

  // The tick counter free-runs once a frame starts, so every bit is sampled
  // exactly 16 ticks after the previous one.
  assign rx_sample = (rx_tick_q == MID_SAMPLE);
  assign rx_push   = (rx_state_q == RX_STOP) && rx_sample;

  always_ff @(posedge mclkx16 or negedge reset) begin
    if (!reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_pmode_q <= PAR_NONE;
      rx_perr_q  <= 1'b0;
    end else begin
      rx_s1_q   <= rx_src;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      // Edge detection also provides re-arming after a framing error: a
      // line stuck low never produces a new falling edge.
      if (rx_state_q == RX_IDLE) begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_q <= RX_START;
          rx_tick_q  <= '0;
          rx_pmode_q <= paritymode;
          rx_perr_q  <= 1'b0;
        end
      end else begin
        rx_tick_q <= rx_tick_q + 4'd1;
        if (rx_sample) begin
          case (rx_state_q)
            RX_START: begin
              rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
              rx_bit_q   <= '0;
            end
            RX_DATA: begin
              rx_shift_q <= {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
              if (rx_bit_q == 3'(DATA_BITS - 1))
                rx_state_q <= parity_enabled(rx_pmode_q) ? RX_PARITY : RX_STOP;
              else
                rx_bit_q <= rx_bit_q + 3'd1;
            end
            RX_PARITY: begin
              rx_perr_q  <= rx_s2_q ^ (^rx_shift_q) ^ (rx_pmode_q == PAR_ODD);
              rx_state_q <= RX_STOP;
            end
            default: rx_state_q <= RX_IDLE;
          endcase
        end
      end
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [DATA_BITS+1:0] fifo_rdata;
  logic                 fifo_full, fifo_empty;
  logic                 fifo_pop;

  assign fifo_pop = !read && !fifo_empty;

  uart_sync_fifo #(
    .WIDTH(DATA_BITS + 2),
    .DEPTH(RX_DEPTH)
  ) u_rx_fifo (
    .clk    (mclkx16),
    .rst_n  (reset),
    .push_i (rx_push),
    .pop_i  (fifo_pop),
    .wdata_i({rx_shift_q, rx_perr_q, !rx_s2_q}),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  logic overrun_q;

  always_ff @(posedge mclkx16 or negedge reset) begin
    if (!reset)
      overrun_q <= 1'b0;
    else if (fifo_pop)
      overrun_q <= 1'b0;
    else if (rx_push && fifo_full)
      overrun_q <= 1'b1;
  end

  assign rxrdy                              = !fifo_empty;
  assign {dataout, parityerr, framingerr}   = fifo_rdata;
  assign overrun                            = overrun_q;

endmodule

// File: tb/tb_uart_fifo_core.sv
// tb/tb_uart_fifo_core.sv - directed table-driven bench for uart_fifo_core
module tb_uart_fifo_core;

  logic       mclkx16 = 1'b0;
  logic       reset;
  logic [1:0] paritymode;
  logic       rx;
  logic       read;
  logic       rxrdy;
  logic [7:0] dataout;
  logic       parityerr;
  logic       framingerr;
  logic       overrun;
  logic       write;
  logic [7:0] datain;
  logic       txrdy;
  logic       tx;
`ifdef UART_LOOPBACK_EN
  logic       loopback = 1'b0;
`endif

  int vectors     = 0;
  int miscompares = 0;

  uart_fifo_core #(.DATA_BITS(8), .STOP_BITS(1), .RX_DEPTH(4)) dut (
    .mclkx16   (mclkx16),
    .reset     (reset),
    .paritymode(paritymode),
    .rx        (rx),
    .read      (read),
    .rxrdy     (rxrdy),
    .dataout   (dataout),
    .parityerr (parityerr),
    .framingerr(framingerr),
    .overrun   (overrun),
    .write     (write),
    .datain    (datain),
    .txrdy     (txrdy),
`ifdef UART_LOOPBACK_EN
    .loopback  (loopback),
`endif
    .tx        (tx)
  );

  always #5 mclkx16 = ~mclkx16;

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  mode;
    logic [10:0] bits;   // bit i = i-th transmitted bit
    int          nbits;
  } tx_vec_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] mode;
    logic       has_par;
    logic       par_bit;
    logic       stop_bit;
    logic       exp_perr;
    logic       exp_ferr;
  } rx_vec_t;

  tx_vec_t tx_tab[5];
  rx_vec_t rx_tab[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge mclkx16);
      #1;
    end
  endtask

  task automatic pop_one();
    read = 1'b0;
    tick(1);
    read = 1'b1;
  endtask

  // Drives one serial frame on rx, one bit per 16 clocks. A single-cycle
  // read pulse is issued at clock offset pop_at (negative: none).
  task automatic send_rx(input logic [7:0] d, input logic has_par, input logic pbit,
                         input logic sbit, input int pop_at);
    logic [10:0] f;
    int          n;
    f      = 11'h7FF;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (has_par) begin
      f[9]  = pbit;
      f[10] = sbit;
      n     = 11;
    end else begin
      f[9] = sbit;
      n    = 10;
    end
    for (int c = 0; c < n * 16; c++) begin
      rx   = f[c / 16];
      read = (c == pop_at) ? 1'b0 : 1'b1;
      tick(1);
    end
    rx   = 1'b1;
    read = 1'b1;
  endtask

  task automatic run_tx(input tx_vec_t v);
    int bad;
    paritymode = v.mode;
    datain     = v.data;
    write      = 1'b0;
    tick(1);
    write  = 1'b1;
    datain = 8'h00;
    for (int b = 0; b < v.nbits; b++) begin
      bad = 0;
      for (int k = 0; k < 16; k++) begin
        if (tx !== v.bits[b] || txrdy !== 1'b0) bad++;
        tick(1);
      end
      check($sformatf("tx %02h bit%0d bad clocks", v.data, b), bad, 0);
    end
    check($sformatf("tx %02h txrdy after frame", v.data), txrdy, 1);
    check($sformatf("tx %02h idle line", v.data), tx, 1);
  endtask

  initial begin
    int bad;
    int waited;

    tx_tab[0] = '{8'h53, 2'b01, 11'h4A6, 11};
    tx_tab[1] = '{8'hA5, 2'b00, 11'h34A, 10};
    tx_tab[2] = '{8'h53, 2'b10, 11'h6A6, 11};
    tx_tab[3] = '{8'h07, 2'b11, 11'h20E, 10};
    tx_tab[4] = '{8'hFF, 2'b01, 11'h5FE, 11};

    rx_tab[0] = '{8'h81, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    rx_tab[1] = '{8'h01, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    rx_tab[2] = '{8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    rx_tab[3] = '{8'hFE, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    rx_tab[4] = '{8'h5A, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    rx_tab[5] = '{8'h6B, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    reset      = 1'b0;
    paritymode = 2'b00;
    rx         = 1'b1;
    read       = 1'b1;
    write      = 1'b1;
    datain     = 8'h00;
    tick(3);
    check("reset tx", tx, 1);
    check("reset txrdy", txrdy, 1);
    check("reset rxrdy", rxrdy, 0);
    check("reset dataout", dataout, 0);
    check("reset parityerr", parityerr, 0);
    check("reset framingerr", framingerr, 0);
    check("reset overrun", overrun, 0);
    reset = 1'b1;
    tick(4);

    // TX frames
    for (int i = 0; i < 5; i++) begin
      run_tx(tx_tab[i]);
      tick(3);
    end

    // reset in the middle of a transmit
    paritymode = 2'b00;
    datain     = 8'hA5;
    write      = 1'b0;
    tick(1);
    write = 1'b1;
    tick(40);
    check("mid-frame tx low", tx, 0);
    reset = 1'b0;
    #1;
    check("async reset tx", tx, 1);
    check("async reset txrdy", txrdy, 1);
    #2;
    reset = 1'b1;
    bad   = 0;
    for (int c = 0; c < 200; c++) begin
      tick(1);
      if (tx !== 1'b1) bad++;
    end
    check("no residual frame", bad, 0);
    check("txrdy after abort", txrdy, 1);

    // RX table: each frame received, checked, then popped
    for (int i = 0; i < 6; i++) begin
      paritymode = rx_tab[i].mode;
      send_rx(rx_tab[i].data, rx_tab[i].has_par, rx_tab[i].par_bit, rx_tab[i].stop_bit, -1);
      tick(4);
      check($sformatf("rx[%0d] rxrdy", i), rxrdy, 1);
      check($sformatf("rx[%0d] dataout", i), dataout, rx_tab[i].data);
      check($sformatf("rx[%0d] parityerr", i), parityerr, rx_tab[i].exp_perr);
      check($sformatf("rx[%0d] framingerr", i), framingerr, rx_tab[i].exp_ferr);
      pop_one();
      check($sformatf("rx[%0d] empty after pop", i), rxrdy, 0);
      check($sformatf("rx[%0d] dataout held", i), dataout, rx_tab[i].data);
    end

    // two frames back to back, odd parity, second with a wrong parity bit
    paritymode = 2'b10;
    send_rx(8'hC3, 1'b1, 1'b1, 1'b1, -1);
    send_rx(8'h3A, 1'b1, 1'b0, 1'b1, -1);
    tick(4);
    check("pair head rxrdy", rxrdy, 1);
    check("pair head data", dataout, 8'hC3);
    check("pair head parityerr", parityerr, 0);
    pop_one();
    check("pair second data", dataout, 8'h3A);
    check("pair second parityerr", parityerr, 1);
    check("pair second rxrdy", rxrdy, 1);
    pop_one();
    check("pair drained", rxrdy, 0);

    // short low glitch is a false start
    paritymode = 2'b00;
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(60);
    check("glitch no push", rxrdy, 0);

    // five frames into a 4-deep FIFO with no reads
    send_rx(8'h11, 1'b0, 1'b0, 1'b1, -1);
    send_rx(8'h22, 1'b0, 1'b0, 1'b1, -1);
    send_rx(8'h33, 1'b0, 1'b0, 1'b1, -1);
    send_rx(8'h44, 1'b0, 1'b0, 1'b1, -1);
    check("four stored no overrun", overrun, 0);
    send_rx(8'h55, 1'b0, 1'b0, 1'b1, -1);
    tick(4);
    check("overrun set", overrun, 1);
    check("overrun head", dataout, 8'h11);
    pop_one();
    check("overrun cleared by pop", overrun, 0);
    check("after pop 1", dataout, 8'h22);
    pop_one();
    check("after pop 2", dataout, 8'h33);
    pop_one();
    check("after pop 3", dataout, 8'h44);
    pop_one();
    check("fifth char lost", rxrdy, 0);
    check("last value held", dataout, 8'h44);

    // push coincident with a pop at full: the 8N1 stop sample writes the
    // FIFO on the clock edge 155 clocks after the start bit is driven
    send_rx(8'hA1, 1'b0, 1'b0, 1'b1, -1);
    send_rx(8'hA2, 1'b0, 1'b0, 1'b1, -1);
    send_rx(8'hA3, 1'b0, 1'b0, 1'b1, -1);
    send_rx(8'hA4, 1'b0, 1'b0, 1'b1, -1);
    send_rx(8'hA5, 1'b0, 1'b0, 1'b1, 154);
    tick(4);
    check("coincident no overrun", overrun, 0);
    check("coincident head", dataout, 8'hA2);
    pop_one();
    check("coincident pop A3", dataout, 8'hA3);
    pop_one();
    check("coincident pop A4", dataout, 8'hA4);
    pop_one();
    check("coincident push kept A5", dataout, 8'hA5);
    pop_one();
    check("coincident drained", rxrdy, 0);

`ifdef UART_LOOPBACK_EN
    loopback   = 1'b1;
    paritymode = 2'b00;
    tick(4);
    datain = 8'h3C;
    write  = 1'b0;
    tick(1);
    write  = 1'b1;
    bad    = 0;
    waited = 0;
    while (rxrdy !== 1'b1 && waited < 400) begin
      if (tx !== 1'b1) bad++;
      tick(1);
      waited++;
    end
    check("loopback rxrdy within bound", rxrdy, 1);
    check("loopback external tx idle", bad, 0);
    check("loopback dataout", dataout, 8'h3C);
    tick(40);
    pop_one();
    loopback = 1'b0;
`else
    waited = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
